neighbor_pattern_gen: RTL and testbench



---
 rtl/npg_pkg.sv | 34 +++
 rtl/same_popcount_next.sv | 40 ++++
 rtl/neighbor_pattern_gen.sv | 94 +++++++++
 tb/tb_neighbor_pattern_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/npg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | npg_pkg : shared constants, FSM states and pattern-bound helpers    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package npg_pkg;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Lowest value with cnt bits set; cnt must not exceed N.
    function automatic logic [N-1:0] first_pattern(input logic [CW-1:0] cnt);
        logic [N:0] ones;
        ones = ((N+1)'(1) << cnt) - (N+1)'(1);
        return ones[N-1:0];
    endfunction

    // Highest value with cnt bits set (top cnt bits); cnt must not exceed N.
    function automatic logic [N-1:0] last_pattern(input logic [CW-1:0] cnt);
        logic [N:0] ones;
        logic [N:0] shifted;
        ones    = ((N+1)'(1) << cnt) - (N+1)'(1);
        shifted = ones << (CW'(N) - cnt);
        return shifted[N-1:0];
    endfunction

endpackage : npg_pkg
`default_nettype wire

// File: rtl/same_popcount_next.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | same_popcount_next : smallest value above v_i with equal popcount   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module same_popcount_next
    import npg_pkg::*;
(
    input  logic [N-1:0] v_i,
    output logic [N-1:0] succ_o
);

    localparam logic [N:0] ONE = (N+1)'(1);

    logic [CW-1:0] ctz;
    logic [N:0]    v_ext;
    logic [N:0]    t;
    logic [N:0]    t_inc;
    logic [N:0]    low_fill;
    logic [N:0]    succ_ext;

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        ctz = CW'(N);
        for (int i = N - 1; i >= 0; i--) begin
            if (v_i[i]) begin
                ctz = CW'(i);
            end
        end
    end

    assign v_ext    = {1'b0, v_i};
    assign t        = v_ext | (v_ext - ONE);
    assign t_inc    = t + ONE;
    assign low_fill = ((~t & t_inc) - ONE) >> (ctz + CW'(1));
    assign succ_ext = t_inc | low_fill;
    assign succ_o   = succ_ext[N-1:0];

endmodule : same_popcount_next
`default_nettype wire

// File: rtl/neighbor_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | neighbor_pattern_gen : enumerates all N-bit patterns of a given     |
// | popcount in ascending order over a valid/ready stream               |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module neighbor_pattern_gen
    import npg_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] count,
    output logic [N-1:0]  pattern,
    output logic          valid,
    input  logic          ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state_q;
    logic [N-1:0]  pattern_q;
    logic [N-1:0]  last_q;
    logic          valid_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic [N-1:0]  pattern_d;

    same_popcount_next u_next (
        .v_i    (pattern_q),
        .succ_o (pattern_d)
    );

    // The final pattern is captured at start so later count changes cannot
    // disturb an enumeration in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            last_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (count <= CW'(N)) begin
                            pattern_q <= first_pattern(count);
                            last_q    <= last_pattern(count);
                            valid_q   <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= S_EMIT;
                        end else begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (ready) begin
                        if (pattern_q == last_q) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            pattern_q <= pattern_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pattern = pattern_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule : neighbor_pattern_gen
`default_nettype wire

// File: tb/tb_neighbor_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_neighbor_pattern_gen : randomized self-checking bench            |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_neighbor_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] count = '0;
    logic [7:0] pattern;
    logic       valid;
    logic       ready = 1'b0;
    logic       busy;
    logic       done;
    logic       err;

    int nchk  = 0;
    int nfail = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         exp_idx = 0;
    int         done_cnt = 0;
    bit         mon_en = 1'b0;
    bit         exp_done_now = 1'b0;

    int binom[9] = '{1, 8, 28, 56, 70, 56, 28, 8, 1};

    neighbor_pattern_gen dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .count   (count),
        .pattern (pattern),
        .valid   (valid),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        nchk++;
        if (got !== expv) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
        end
    endtask

    // Reference: every byte with k bits set, ascending.
    task automatic build_exp(input int k);
        exp_q.delete();
        for (int v = 0; v < 256; v++) begin
            if ($countones(v[7:0]) == k) exp_q.push_back(v[7:0]);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return {24'd0, got_q[i]};
        return 32'hDEAD;
    endfunction

    // Stream monitor: compares every visible beat and the done/err flags.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("done_flag", {31'd0, done}, {31'd0, exp_done_now});
                check("err_flag", {31'd0, err}, 32'd0);
                if (exp_done_now && done) done_cnt++;
                exp_done_now = 1'b0;
                if (valid) begin
                    check("busy_while_valid", {31'd0, busy}, 32'd1);
                    if (exp_idx >= exp_q.size()) begin
                        nchk++;
                        nfail++;
                        $display("FAIL extra_beat: got 0x%0h expected no beat", pattern);
                    end else begin
                        check("pattern", {24'd0, pattern}, {24'd0, exp_q[exp_idx]});
                        if (ready) begin
                            got_q.push_back(pattern);
                            exp_idx++;
                            if (exp_idx == exp_q.size()) exp_done_now = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic run_enum(input int k, input bit rnd_ready, input bit mid_start);
        int cyc;
        build_exp(k);
        got_q.delete();
        exp_idx      = 0;
        done_cnt     = 0;
        exp_done_now = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        count = 4'(k);
        ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("first_valid_latency", {31'd0, valid}, 32'd1);
        cyc = 0;
        while (cyc < 3000) begin
            @(posedge clk); #1;
            ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mid_start && cyc == 20) begin
                start = 1'b1;
                count = 4'd2;
            end else begin
                start = 1'b0;
            end
            cyc++;
            @(negedge clk);
            if (done) break;
        end
        if (!done) begin
            nchk++;
            nfail++;
            $display("FAIL done_timeout: got no done expected done within 3000 cycles (k=%0d)", k);
        end else if (!rnd_ready) begin
            check("done_cycle", cyc, binom[k]);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("done_pulse_width", {31'd0, done}, 32'd0);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("valid_after_done", {31'd0, valid}, 32'd0);
        check("done_count", done_cnt, 32'd1);
        check("beat_total", exp_idx, binom[k]);
        mon_en = 1'b0;
    endtask

    task automatic run_err(input int k);
        @(posedge clk); #1;
        start = 1'b1;
        count = 4'(k);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("err_done", {31'd0, done}, 32'd1);
        check("err_err", {31'd0, err}, 32'd1);
        check("err_valid", {31'd0, valid}, 32'd0);
        check("err_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("err_done_drop", {31'd0, done}, 32'd0);
        check("err_err_drop", {31'd0, err}, 32'd0);
        check("err_valid_after", {31'd0, valid}, 32'd0);
    endtask

    task automatic run_reset_case();
        build_exp(5);
        @(posedge clk); #1;
        start = 1'b1;
        count = 4'd5;
        ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        count = 4'($urandom_range(0, 15));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_case_beat", {24'd0, pattern}, {24'd0, exp_q[i]});
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_case_beat11", {24'd0, pattern}, {24'd0, exp_q[10]});
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_pattern", {24'd0, pattern}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_done", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_pattern", {24'd0, pattern}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);

        run_enum(0, 1'b0, 1'b0);
        check("k0_beat", got_at(0), 32'h00);

        run_enum(1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) check("k1_beat", got_at(i), 32'(1 << i));

        run_enum(4, 1'b0, 1'b0);
        check("k4_first", got_at(0), 32'h0F);
        check("k4_second", got_at(1), 32'h17);
        check("k4_third", got_at(2), 32'h1B);
        check("k4_last", got_at(69), 32'hF0);

        run_err(9);
        run_err(15);

        run_enum(3, 1'b1, 1'b1);

        for (int r = 0; r < 4; r++) run_enum($urandom_range(0, 8), 1'b1, 1'b0);

        run_reset_case();
        run_enum(8, 1'b0, 1'b0);
        check("k8_beat", got_at(0), 32'hFF);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule : tb_neighbor_pattern_gen
`default_nettype wire
